// File: rtl/msi_message_generator_if.sv
// MSI memory-write request channel between the message generator and the TLP transmit path.
// tx_valid rises with a stable payload and stays up until the cycle tx_valid && tx_ready; irq_sent marks that cycle.
interface msi_message_generator_if;
   logic        tx_valid;
   logic        tx_ready;
   logic [63:0] tx_addr;
   logic [31:0] tx_data;
   logic [4:0]  tx_vector;
   logic        irq_sent;

   modport master (
      output tx_valid,
      output tx_addr,
      output tx_data,
      output tx_vector,
      output irq_sent,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_addr,
      input  tx_data,
      input  tx_vector,
      input  irq_sent,
      output tx_ready
   );
endinterface

// File: rtl/msi_message_generator.sv
// MSI transmit side: collects per-vector requests into pending bits and issues one
// memory-write request per eligible vector, lowest vector first.
module msi_message_generator #(
   parameter int NUM_VECTORS = 32,
   parameter bit ADDR64      = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   msi_enable,
   input  logic                   bus_master_en,
   input  logic [31:0]            cfg_msg_addr,
   input  logic [31:0]            cfg_msg_upper_addr,
   input  logic [15:0]            cfg_msg_data,
   input  logic [2:0]             cfg_mme,
   input  logic [NUM_VECTORS-1:0] cfg_mask,
   input  logic [NUM_VECTORS-1:0] irq_req,
   output logic [NUM_VECTORS-1:0] pending,
   msi_message_generator_if.master tx,
   output logic                   dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [NUM_VECTORS-1:0] pending_q, pending_d;
   logic [63:0]            tx_addr_q, tx_addr_d;
   logic [31:0]            tx_data_q, tx_data_d;
   logic [4:0]             tx_vector_q, tx_vector_d;

   logic [2:0]             mme_c;
   logic [5:0]             alloc;
   logic [4:0]             fold_mask;
   logic [NUM_VECTORS-1:0] valid_mask;
   logic [NUM_VECTORS-1:0] set_c;
   logic [NUM_VECTORS-1:0] clear_c;
   logic [NUM_VECTORS-1:0] eligible;
   logic [4:0]             sel_vec;
   logic [63:0]            addr_c;
   logic                   tx_valid_c;
   logic                   handshake;
   logic [1:0]             unused_addr_bits;

   assign unused_addr_bits = cfg_msg_addr[1:0];

   // Allocated vector count: 2^min(mme,5), never more than the sources that exist.
   always_comb begin
      mme_c = (cfg_mme > 3'd5) ? 3'd5 : cfg_mme;
      alloc = 6'd1 << mme_c;
      if (alloc > 6'(NUM_VECTORS)) begin
         alloc = 6'(NUM_VECTORS);
      end
      fold_mask = 5'(alloc - 6'd1);
      for (int i = 0; i < NUM_VECTORS; i++) begin
         valid_mask[i] = (6'(i) < alloc);
      end
   end

   assign tx_valid_c = (state_q == SEND);
   assign handshake  = tx_valid_c && tx.tx_ready;

   always_comb begin
      set_c   = '0;
      clear_c = '0;
      for (int v = 0; v < NUM_VECTORS; v++) begin
         if (irq_req[v]) begin
            set_c[5'(v) & fold_mask] = 1'b1;
         end
         if (handshake && (tx_vector_q == 5'(v))) begin
            clear_c[v] = 1'b1;
         end
      end
      set_c = set_c & valid_mask;
   end

   // Set is applied after clear so a request landing on the handshake cycle re-arms the bit.
   always_comb begin
      if (msi_enable) begin
         pending_d = ((pending_q & ~clear_c) | set_c) & valid_mask;
      end else begin
         pending_d = '0;
      end
   end

   assign eligible = pending_q & ~cfg_mask;

   always_comb begin
      sel_vec = 5'd0;
      for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_vec = 5'(i);
         end
      end
   end

   always_comb begin
      if (ADDR64 && (cfg_msg_upper_addr != 32'h0)) begin
         addr_c = {cfg_msg_upper_addr, cfg_msg_addr[31:2], 2'b00};
      end else begin
         addr_c = {32'h0, cfg_msg_addr[31:2], 2'b00};
      end
   end

   always_comb begin
      state_d     = state_q;
      tx_addr_d   = tx_addr_q;
      tx_data_d   = tx_data_q;
      tx_vector_d = tx_vector_q;
      case (state_q)
         IDLE: begin
            if (msi_enable && bus_master_en && (eligible != '0)) begin
               state_d     = SEND;
               tx_vector_d = sel_vec;
               tx_addr_d   = addr_c;
               tx_data_d   = {16'h0, (cfg_msg_data & ~{11'h0, fold_mask}) | {11'h0, sel_vec}};
            end
         end
         SEND: begin
            if (tx.tx_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         tx_addr_q   <= 64'h0;
         tx_data_q   <= 32'h0;
         tx_vector_q <= 5'd0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         tx_addr_q   <= tx_addr_d;
         tx_data_q   <= tx_data_d;
         tx_vector_q <= tx_vector_d;
      end
   end

   assign pending      = pending_q;
   assign tx.tx_valid  = tx_valid_c;
   assign tx.tx_addr   = tx_addr_q;
   assign tx.tx_data   = tx_data_q;
   assign tx.tx_vector = tx_vector_q;
   assign tx.irq_sent  = handshake;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_msi_message_generator.sv
// Directed bench for msi_message_generator: each task drives one scenario and checks
// outputs against hand-computed values; completed messages are logged for per-test checks.
module tb_msi_message_generator;

   logic        clk;
   logic        rst_n;
   logic        msi_enable;
   logic        bus_master_en;
   logic [31:0] cfg_msg_addr;
   logic [31:0] cfg_msg_upper_addr;
   logic [15:0] cfg_msg_data;
   logic [2:0]  cfg_mme;
   logic [31:0] cfg_mask;
   logic [31:0] irq_req;
   logic [31:0] pending;
   logic        dbg_state;

   int n_vec;
   int n_err;
   logic [31:0] sent_q[$];

   msi_message_generator_if tx_if ();

   msi_message_generator #(.NUM_VECTORS(32), .ADDR64(1'b1)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .msi_enable         (msi_enable),
      .bus_master_en      (bus_master_en),
      .cfg_msg_addr       (cfg_msg_addr),
      .cfg_msg_upper_addr (cfg_msg_upper_addr),
      .cfg_msg_data       (cfg_msg_data),
      .cfg_mme            (cfg_mme),
      .cfg_mask           (cfg_mask),
      .irq_req            (irq_req),
      .pending            (pending),
      .tx                 (tx_if),
      .dbg_state_o        (dbg_state)
   );

   // Clock and message log
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_if.irq_sent === 1'b1) sent_q.push_back(tx_if.tx_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [31:0] v);
      irq_req = v;
      tick();
      irq_req = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h exp 0", pending); end
      n_vec++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", tx_if.tx_valid); end
      n_vec++; if (tx_if.tx_addr !== 64'h0) begin n_err++; $display("FAIL reset_addr: got %h exp 0", tx_if.tx_addr); end
      n_vec++; if (tx_if.tx_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0", tx_if.tx_data); end
      n_vec++; if (tx_if.tx_vector !== 5'd0) begin n_err++; $display("FAIL reset_vector: got %0d exp 0", tx_if.tx_vector); end
      n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b exp 0", dbg_state); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      cfg_mme = 3'd0; cfg_msg_data = 16'h4021; tx_if.tx_ready = 1'b1;
      pulse(32'h1);
      n_vec++; if (pending !== 32'h1) begin n_err++; $display("FAIL single_pend_set: got %h exp 1", pending); end
      n_vec++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b exp 0", tx_if.tx_valid); end
      tick();
      n_vec++; if (tx_if.tx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", tx_if.tx_valid); end
      n_vec++; if (tx_if.tx_addr !== 64'h0000_0000_FEE0_1000) begin n_err++; $display("FAIL single_addr: got %h exp 00000000fee01000", tx_if.tx_addr); end
      n_vec++; if (tx_if.tx_data !== 32'h0000_4021) begin n_err++; $display("FAIL single_data: got %h exp 00004021", tx_if.tx_data); end
      n_vec++; if (tx_if.irq_sent !== 1'b1) begin n_err++; $display("FAIL single_sent: got %b exp 1", tx_if.irq_sent); end
      tick();
      n_vec++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop: got %b exp 0", tx_if.tx_valid); end
      n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL single_pend_clr: got %h exp 0", pending); end
      tick(); tick();
      n_vec++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d exp 1", sent_q.size()); end
      sent_q.delete();
   endtask

   task automatic test_multi();
      cfg_mme = 3'd2; cfg_msg_data = 16'h4020;
      pulse(32'h0000_000A);
      n_vec++; if (pending !== 32'h0000_000A) begin n_err++; $display("FAIL multi_pend: got %h exp 0000000a", pending); end
      tick();
      n_vec++; if (tx_if.tx_vector !== 5'd1) begin n_err++; $display("FAIL multi_vec1: got %0d exp 1", tx_if.tx_vector); end
      n_vec++; if (tx_if.tx_data !== 32'h0000_4021) begin n_err++; $display("FAIL multi_data1: got %h exp 00004021", tx_if.tx_data); end
      tick();
      n_vec++; if (pending !== 32'h0000_0008) begin n_err++; $display("FAIL multi_pend_after1: got %h exp 00000008", pending); end
      n_vec++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL multi_idle_gap: got %b exp 0", tx_if.tx_valid); end
      tick();
      n_vec++; if (tx_if.tx_data !== 32'h0000_4023) begin n_err++; $display("FAIL multi_data3: got %h exp 00004023", tx_if.tx_data); end
      tick();
      n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL multi_pend_empty: got %h exp 0", pending); end
      // bits 6 and 2 both fold to vector 2 and must merge into one message
      pulse(32'h0000_0044);
      n_vec++; if (pending !== 32'h0000_0004) begin n_err++; $display("FAIL multi_fold_pend: got %h exp 00000004", pending); end
      tick();
      n_vec++; if (tx_if.tx_data !== 32'h0000_4022) begin n_err++; $display("FAIL multi_fold_data: got %h exp 00004022", tx_if.tx_data); end
      tick(); tick(); tick();
      n_vec++; if (sent_q.size() !== 3) begin n_err++; $display("FAIL multi_count: got %0d exp 3", sent_q.size()); end
      if (sent_q.size() == 3) begin
         n_vec++; if (sent_q[0] !== 32'h4021 || sent_q[1] !== 32'h4023 || sent_q[2] !== 32'h4022) begin
            n_err++; $display("FAIL multi_order: got %h %h %h exp 4021 4023 4022", sent_q[0], sent_q[1], sent_q[2]);
         end
      end
      sent_q.delete();
      cfg_mme = 3'd0; cfg_msg_data = 16'h4021;
   endtask

   task automatic test_mask();
      int held_bad;
      held_bad = 0;
      cfg_mask = 32'h1;
      pulse(32'h1);
      for (int i = 0; i < 20; i++) begin
         if (tx_if.tx_valid !== 1'b0 || pending !== 32'h1) held_bad++;
         tick();
      end
      n_vec++; if (held_bad !== 0) begin n_err++; $display("FAIL mask_hold: got %0d bad cycles exp 0", held_bad); end
      cfg_mask = 32'h0;
      tick();
      n_vec++; if (tx_if.tx_valid !== 1'b1) begin n_err++; $display("FAIL mask_release: got %b exp 1", tx_if.tx_valid); end
      tick();
      n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL mask_pend_clr: got %h exp 0", pending); end
      tick();
      n_vec++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL mask_count: got %0d exp 1", sent_q.size()); end
      sent_q.delete();
   endtask

   task automatic test_backpressure();
      int unstable;
      unstable = 0;
      tx_if.tx_ready = 1'b0;
      cfg_msg_data = 16'h4021;
      pulse(32'h1);
      tick();
      for (int c = 1; c <= 10; c++) begin
         if (c == 3) msi_enable = 1'b0;
         if (tx_if.tx_valid !== 1'b1 || tx_if.tx_addr !== 64'h0000_0000_FEE0_1000 ||
             tx_if.tx_data !== 32'h0000_4021 || tx_if.tx_vector !== 5'd0) unstable++;
         tick();
      end
      n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles exp 0", unstable); end
      n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL bp_pend_disabled: got %h exp 0", pending); end
      tx_if.tx_ready = 1'b1;
      #1;
      n_vec++; if (tx_if.irq_sent !== 1'b1) begin n_err++; $display("FAIL bp_sent: got %b exp 1", tx_if.irq_sent); end
      tick();
      pulse(32'h1);
      n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL bp_no_set: got %h exp 0", pending); end
      msi_enable = 1'b1;
      tick(); tick(); tick();
      n_vec++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL bp_count: got %0d exp 1", sent_q.size()); end
      sent_q.delete();
   endtask

   task automatic test_64bit();
      int leaked;
      leaked = 0;
      cfg_msg_upper_addr = 32'h0000_0001;
      cfg_msg_addr = 32'hFEE0_1003;
      bus_master_en = 1'b0;
      pulse(32'h1);
      for (int i = 0; i < 5; i++) begin
         if (tx_if.tx_valid !== 1'b0) leaked++;
         tick();
      end
      n_vec++; if (leaked !== 0) begin n_err++; $display("FAIL bme_gate: got %0d valid cycles exp 0", leaked); end
      n_vec++; if (pending !== 32'h1) begin n_err++; $display("FAIL bme_pend: got %h exp 1", pending); end
      bus_master_en = 1'b1;
      tick();
      n_vec++; if (tx_if.tx_addr !== 64'h0000_0001_FEE0_1000) begin n_err++; $display("FAIL addr64: got %h exp 00000001fee01000", tx_if.tx_addr); end
      tick(); tick();
      n_vec++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL addr64_count: got %0d exp 1", sent_q.size()); end
      sent_q.delete();
      cfg_msg_upper_addr = 32'h0;
      cfg_msg_addr = 32'hFEE0_1000;
   endtask

   task automatic test_collision_reset();
      pulse(32'h1);
      tick();
      irq_req = 32'h1;
      tick();
      irq_req = 32'h0;
      n_vec++; if (pending !== 32'h1) begin n_err++; $display("FAIL coll_pend: got %h exp 1", pending); end
      n_vec++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL coll_gap: got %b exp 0", tx_if.tx_valid); end
      tick();
      n_vec++; if (tx_if.tx_valid !== 1'b1) begin n_err++; $display("FAIL coll_second: got %b exp 1", tx_if.tx_valid); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (tx_if.tx_valid !== 1'b0 || dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_send_state: got valid=%b state=%b exp 0 0", tx_if.tx_valid, dbg_state); end
      n_vec++; if (tx_if.tx_addr !== 64'h0 || tx_if.tx_data !== 32'h0 || pending !== 32'h0) begin
         n_err++; $display("FAIL rst_send_regs: got addr=%h data=%h pend=%h exp 0", tx_if.tx_addr, tx_if.tx_data, pending);
      end
      tick();
      rst_n = 1'b1;
      tick(); tick();
      n_vec++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL coll_count: got %0d exp 1", sent_q.size()); end
      sent_q.delete();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      msi_enable = 1'b1;
      bus_master_en = 1'b1;
      cfg_msg_addr = 32'hFEE0_1000;
      cfg_msg_upper_addr = 32'h0;
      cfg_msg_data = 16'h4021;
      cfg_mme = 3'd0;
      cfg_mask = 32'h0;
      irq_req = 32'h0;
      tx_if.tx_ready = 1'b1;
      test_reset();
      test_single();
      test_multi();
      test_mask();
      test_backpressure();
      test_64bit();
      test_collision_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/msi_message_generator.md
Name: msi_message_generator

Overview:
- Transmit-side counterpart of the MSI capability registers.
- Accepts per-vector interrupt requests from function logic and holds them as pending bits.
- Arbitrates among pending, unmasked vectors and issues one MSI memory-write request per vector toward the TLP transmit path.
- Address comes from the programmed Message Address/Upper Address; data is the Message Data with the vector number merged in.

Parameters:
- NUM_VECTORS, 32, number of interrupt sources, 1..32.
- ADDR64, 1, 1 = 64-bit address capable (upper address used), 0 = upper address ignored.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- msi_enable  input  1  MSI Enable bit from the capability
- bus_master_en  input  1  Command register Bus Master Enable
- cfg_msg_addr  input  32  Message Address register; bits [1:0] ignored
- cfg_msg_upper_addr  input  32  Message Upper Address register
- cfg_msg_data  input  16  Message Data register
- cfg_mme  input  3  Multiple Message Enable (log2 of allocated vectors)
- cfg_mask  input  NUM_VECTORS  per-vector Mask bits
- irq_req  input  NUM_VECTORS  one-cycle request pulses, one bit per vector
- pending  output  NUM_VECTORS  Pending bits, for the capability read path
- tx_valid  output  1  write request valid
- tx_ready  input  1  downstream accepts request
- tx_addr  output  64  DW-aligned target address
- tx_data  output  32  message payload
- tx_vector  output  5  vector being sent
- irq_sent  output  1  handshake completed this cycle

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, tx_valid=0, tx_addr=0, tx_data=0, tx_vector=0, FSM=IDLE. Deassertion is synchronised externally.
- Allocation
  - alloc = 2^min(cfg_mme,5), further capped at NUM_VECTORS.
  - A request on vector v folds to v & (alloc-1); multiple requests folding to one vector set one bit.
- Pending update, every clock
  - pending_next = (pending & ~clear) | set.
  - set = folded irq_req, gated by msi_enable.
  - clear = one-hot of tx_vector on tx_valid && tx_ready.
  - Set wins over clear on the same bit in the same cycle: pending stays 1 and a second message follows.
  - msi_enable low: pending is cleared to 0 and no new bits are set.
  - Bits at or above alloc are held 0.
- Eligible = pending & ~cfg_mask. Masked vectors stay pending and are issued after unmask.
- FSM
  - IDLE: if msi_enable && bus_master_en && eligible != 0, latch:
    - tx_vector = lowest-numbered eligible bit;
    - tx_addr;
    - tx_data;
    - then go to SEND. Otherwise stay in IDLE.
  - SEND: tx_valid=1. tx_addr, tx_data and tx_vector are stable until the handshake. On tx_valid && tx_ready go to IDLE.
  - tx_valid is never withdrawn before the handshake, even if msi_enable, bus_master_en or the mask drops mid-request.
- tx_addr
  - {cfg_msg_upper_addr, cfg_msg_addr[31:2], 2'b00} when ADDR64=1 and upper != 0.
  - Otherwise {32'h0, cfg_msg_addr[31:2], 2'b00}.
- tx_data[15:0] = (cfg_msg_data & ~(alloc-1)) | tx_vector, zero-extended to 16 bits; tx_data[31:16] = 0.
- irq_sent = tx_valid && tx_ready (combinational).
- Latency
  - A request pulse sampled at edge N sets pending after N.
  - SEND is entered at N+1, so tx_valid is high from N+1.
  - With tx_ready=1, the handshake occurs at edge N+2.
  - Minimum of one IDLE cycle between messages, so peak rate is one message per 2 clocks.
- Configuration changes while in SEND affect only the next message.

Test Plan:
- Single vector: mme=0, addr=32'hFEE0_1000, upper=0, data=16'h4021, irq_req[0] pulse, tx_ready=1 -> tx_valid high 1 cycle after pulse; tx_addr=64'h0000_0000_FEE0_1000, tx_data=32'h0000_4021; pending[0] 1 then 0; one irq_sent.
- Multi-vector merge and priority: mme=2, data=16'h4020, irq_req[3] and irq_req[1] in the same cycle -> vector 1 first (tx_data=32'h0000_4021), then vector 3 (32'h0000_4023); irq_req[6] pulse -> folds to vector 2.
- Mask: cfg_mask[0]=1, irq_req[0] -> pending[0]=1 with no tx_valid for 20 cycles; clear the mask -> message issued and pending[0] cleared.
- Backpressure and enable drop: tx_ready=0 for 10 cycles, msi_enable dropped in cycle 3 -> tx_valid and payload held stable; handshake completes when tx_ready=1; afterwards pending=0 and no further messages.
- 64-bit and gating: upper=32'h0000_0001, bus_master_en=0, request vector 0 -> pending held with no tx_valid; bus_master_en=1 -> tx_addr=64'h0000_0001_FEE0_1000.
- Set/clear collision and reset: irq_req[0] in the handshake cycle -> second message follows; assert rst_n low while in SEND -> all outputs 0 and FSM=IDLE immediately.
